pipeline_stage_reg: RTL and testbench



---
 rtl/pipeline_stage_reg.sv | 112 +++++++++++
 tb/tb_pipeline_stage_reg.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_reg.sv
// Parametrised inter-stage pipeline register chain with hold/bubble stall, flush
// and saturating debug counters for stall and flush events.
module pipeline_stage_reg #(
    parameter int unsigned       WIDTH      = 32,
    parameter int unsigned       PC_WIDTH   = 32,
    parameter int unsigned       DEPTH      = 1,
    parameter int unsigned       STALL_MODE = 0,
    parameter logic [WIDTH-1:0]  NOP_VALUE  = '0,
    parameter int unsigned       CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [PC_WIDTH-1:0]  pc_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic                 valid_o,
    output logic [PC_WIDTH-1:0]  pc_o,
    output logic [WIDTH-1:0]     data_o,
    output logic [2:0]           occupancy_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    if ((DEPTH < 1) || (DEPTH > 4)) begin : g_bad_depth
        $error("pipeline_stage_reg: DEPTH must be in 1..4");
    end

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [PC_WIDTH-1:0]  pc_q   [DEPTH];
    logic [PC_WIDTH-1:0]  pc_d   [DEPTH];
    logic [WIDTH-1:0]     data_q [DEPTH];
    logic [WIDTH-1:0]     data_d [DEPTH];
    logic [2:0]           occ_q, occ_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        data_d      = data_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        occ_d       = '0;

        if (flush_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                valid_d[k] = 1'b0;
                pc_d[k]    = '0;
                data_d[k]  = NOP_VALUE;
            end
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (stall_i) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            // Bubble mode: downstream keeps draining while stage 0 takes a NOP.
            if (STALL_MODE == 1) begin
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    valid_d[k] = valid_q[k-1];
                    pc_d[k]    = pc_q[k-1];
                    data_d[k]  = data_q[k-1];
                end
                valid_d[0] = 1'b0;
                pc_d[0]    = '0;
                data_d[0]  = NOP_VALUE;
            end
        end else begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                pc_d[k]    = pc_q[k-1];
                data_d[k]  = data_q[k-1];
            end
            valid_d[0] = valid_i;
            pc_d[0]    = pc_i;
            data_d[0]  = data_i;
        end

        for (int unsigned k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + {2'b00, valid_d[k]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            occ_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                pc_q[k]   <= '0;
                data_q[k] <= NOP_VALUE;
            end
        end else begin
            valid_q     <= valid_d;
            occ_q       <= occ_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                pc_q[k]   <= pc_d[k];
                data_q[k] <= data_d[k];
            end
        end
    end

    assign valid_o     = valid_q[DEPTH-1];
    assign pc_o        = pc_q[DEPTH-1];
    assign data_o      = data_q[DEPTH-1];
    assign occupancy_o = occ_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed bench for pipeline_stage_reg: three configurations share one stimulus bus.
module tb_pipeline_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, vin;
    logic [31:0] pc, data;

    // a: DEPTH=3 hold, b: DEPTH=1 hold, c: DEPTH=2 bubble with 4-bit counters
    logic        a_v, b_v, c_v;
    logic [31:0] a_pc, b_pc, c_pc, a_d, b_d, c_d;
    logic [2:0]  a_occ, b_occ, c_occ;
    logic [15:0] a_sc, a_fc, b_sc, b_fc;
    logic [3:0]  c_sc, c_fc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeline_stage_reg #(.WIDTH(32), .PC_WIDTH(32), .DEPTH(3), .STALL_MODE(0),
                         .NOP_VALUE(NOP), .CNT_WIDTH(16)) u_a (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(vin),
        .pc_i(pc), .data_i(data), .valid_o(a_v), .pc_o(a_pc), .data_o(a_d),
        .occupancy_o(a_occ), .stall_cnt_o(a_sc), .flush_cnt_o(a_fc));

    pipeline_stage_reg #(.WIDTH(32), .PC_WIDTH(32), .DEPTH(1), .STALL_MODE(0),
                         .NOP_VALUE(NOP), .CNT_WIDTH(16)) u_b (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(vin),
        .pc_i(pc), .data_i(data), .valid_o(b_v), .pc_o(b_pc), .data_o(b_d),
        .occupancy_o(b_occ), .stall_cnt_o(b_sc), .flush_cnt_o(b_fc));

    pipeline_stage_reg #(.WIDTH(32), .PC_WIDTH(32), .DEPTH(2), .STALL_MODE(1),
                         .NOP_VALUE(NOP), .CNT_WIDTH(4)) u_c (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(vin),
        .pc_i(pc), .data_i(data), .valid_o(c_v), .pc_o(c_pc), .data_o(c_d),
        .occupancy_o(c_occ), .stall_cnt_o(c_sc), .flush_cnt_o(c_fc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; vin = 1'b0; pc = '0; data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (a_v !== 1'b0) begin n_errors++; $display("FAIL reset_a_valid got=%b exp=0", a_v); end
        n_checks++; if (a_pc !== 32'h0) begin n_errors++; $display("FAIL reset_a_pc got=%h exp=0", a_pc); end
        n_checks++; if (a_d !== NOP) begin n_errors++; $display("FAIL reset_a_data got=%h exp=%h", a_d, NOP); end
        n_checks++; if (a_occ !== 3'd0) begin n_errors++; $display("FAIL reset_a_occ got=%0d exp=0", a_occ); end
        n_checks++; if (b_d !== NOP) begin n_errors++; $display("FAIL reset_b_data got=%h exp=%h", b_d, NOP); end
        n_checks++; if (c_v !== 1'b0) begin n_errors++; $display("FAIL reset_c_valid got=%b exp=0", c_v); end
        n_checks++; if ({a_sc, a_fc} !== 32'h0) begin n_errors++; $display("FAIL reset_a_cnt got=%h exp=0", {a_sc, a_fc}); end
        n_checks++; if ({c_sc, c_fc} !== 8'h0) begin n_errors++; $display("FAIL reset_c_cnt got=%h exp=0", {c_sc, c_fc}); end
    endtask

    task automatic test_stream();
        do_reset();
        vin = 1'b1; pc = 32'h100; data = 32'h1; tick();
        n_checks++; if (a_v !== 1'b0) begin n_errors++; $display("FAIL stream_e1_valid got=%b exp=0", a_v); end
        n_checks++; if (a_pc !== 32'h0) begin n_errors++; $display("FAIL stream_e1_pc got=%h exp=0", a_pc); end
        n_checks++; if (a_d !== NOP) begin n_errors++; $display("FAIL stream_e1_data got=%h exp=%h", a_d, NOP); end
        n_checks++; if (a_occ !== 3'd1) begin n_errors++; $display("FAIL stream_e1_occ got=%0d exp=1", a_occ); end
        pc = 32'h104; data = 32'h2; tick();
        n_checks++; if (a_occ !== 3'd2) begin n_errors++; $display("FAIL stream_e2_occ got=%0d exp=2", a_occ); end
        n_checks++; if (a_v !== 1'b0) begin n_errors++; $display("FAIL stream_e2_valid got=%b exp=0", a_v); end
        pc = 32'h108; data = 32'h3; tick();
        n_checks++; if (a_v !== 1'b1) begin n_errors++; $display("FAIL stream_e3_valid got=%b exp=1", a_v); end
        n_checks++; if (a_pc !== 32'h100) begin n_errors++; $display("FAIL stream_e3_pc got=%h exp=100", a_pc); end
        n_checks++; if (a_d !== 32'h1) begin n_errors++; $display("FAIL stream_e3_data got=%h exp=1", a_d); end
        n_checks++; if (a_occ !== 3'd3) begin n_errors++; $display("FAIL stream_e3_occ got=%0d exp=3", a_occ); end
        vin = 1'b0; pc = 32'h10C; data = 32'h4; tick();
        n_checks++; if (a_pc !== 32'h104) begin n_errors++; $display("FAIL stream_e4_pc got=%h exp=104", a_pc); end
        n_checks++; if (a_occ !== 3'd2) begin n_errors++; $display("FAIL stream_e4_occ got=%0d exp=2", a_occ); end
        pc = 32'h0; data = 32'h0; tick();
        n_checks++; if (a_occ !== 3'd1) begin n_errors++; $display("FAIL stream_e5_occ got=%0d exp=1", a_occ); end
        tick();
        // invalid entries still carry their pc/data
        n_checks++; if (a_v !== 1'b0) begin n_errors++; $display("FAIL stream_e6_valid got=%b exp=0", a_v); end
        n_checks++; if (a_pc !== 32'h10C) begin n_errors++; $display("FAIL stream_e6_pc got=%h exp=10c", a_pc); end
        n_checks++; if (a_d !== 32'h4) begin n_errors++; $display("FAIL stream_e6_data got=%h exp=4", a_d); end
    endtask

    task automatic test_hold_stall();
        do_reset();
        vin = 1'b1; pc = 32'h200; data = 32'hABCD; tick();
        n_checks++; if (b_pc !== 32'h200) begin n_errors++; $display("FAIL hold_load_pc got=%h exp=200", b_pc); end
        stall = 1'b1; pc = 32'h204; data = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (b_pc !== 32'h200) begin n_errors++; $display("FAIL hold_pc[%0d] got=%h exp=200", i, b_pc); end
            n_checks++; if (b_d !== 32'hABCD) begin n_errors++; $display("FAIL hold_data[%0d] got=%h exp=abcd", i, b_d); end
            n_checks++; if (b_v !== 1'b1) begin n_errors++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, b_v); end
        end
        n_checks++; if (b_sc !== 16'd3) begin n_errors++; $display("FAIL hold_stall_cnt got=%0d exp=3", b_sc); end
        stall = 1'b0; tick();
        n_checks++; if (b_pc !== 32'h204) begin n_errors++; $display("FAIL hold_resume_pc got=%h exp=204", b_pc); end
        n_checks++; if (b_d !== 32'h1234) begin n_errors++; $display("FAIL hold_resume_data got=%h exp=1234", b_d); end
        n_checks++; if (b_sc !== 16'd3) begin n_errors++; $display("FAIL hold_cnt_after got=%0d exp=3", b_sc); end
    endtask

    task automatic test_bubble_stall();
        do_reset();
        vin = 1'b1; pc = 32'h10; data = 32'hA; tick();
        n_checks++; if (c_occ !== 3'd1) begin n_errors++; $display("FAIL bubble_load_occ got=%0d exp=1", c_occ); end
        stall = 1'b1; pc = 32'h14; data = 32'hB; tick();
        n_checks++; if (c_v !== 1'b1) begin n_errors++; $display("FAIL bubble_e1_valid got=%b exp=1", c_v); end
        n_checks++; if (c_pc !== 32'h10) begin n_errors++; $display("FAIL bubble_e1_pc got=%h exp=10", c_pc); end
        n_checks++; if (c_occ !== 3'd1) begin n_errors++; $display("FAIL bubble_e1_occ got=%0d exp=1", c_occ); end
        n_checks++; if (c_sc !== 4'd1) begin n_errors++; $display("FAIL bubble_stall_cnt got=%0d exp=1", c_sc); end
        stall = 1'b0; vin = 1'b0; pc = 32'h0; data = 32'h0; tick();
        n_checks++; if (c_v !== 1'b0) begin n_errors++; $display("FAIL bubble_e2_valid got=%b exp=0", c_v); end
        n_checks++; if (c_d !== NOP) begin n_errors++; $display("FAIL bubble_e2_data got=%h exp=%h", c_d, NOP); end
        n_checks++; if (c_pc !== 32'h0) begin n_errors++; $display("FAIL bubble_e2_pc got=%h exp=0", c_pc); end
        n_checks++; if (c_occ !== 3'd0) begin n_errors++; $display("FAIL bubble_e2_occ got=%0d exp=0", c_occ); end
    endtask

    task automatic test_flush_with_stall();
        do_reset();
        vin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h400 + 32'(4 * i); data = 32'h40 + 32'(i); tick();
        end
        n_checks++; if (a_occ !== 3'd3) begin n_errors++; $display("FAIL flush_full_occ got=%0d exp=3", a_occ); end
        flush = 1'b1; stall = 1'b1; tick();
        n_checks++; if (a_v !== 1'b0) begin n_errors++; $display("FAIL flush_valid got=%b exp=0", a_v); end
        n_checks++; if (a_occ !== 3'd0) begin n_errors++; $display("FAIL flush_occ got=%0d exp=0", a_occ); end
        n_checks++; if (a_d !== NOP) begin n_errors++; $display("FAIL flush_data got=%h exp=%h", a_d, NOP); end
        n_checks++; if (a_pc !== 32'h0) begin n_errors++; $display("FAIL flush_pc got=%h exp=0", a_pc); end
        n_checks++; if (a_fc !== 16'd1) begin n_errors++; $display("FAIL flush_cnt got=%0d exp=1", a_fc); end
        n_checks++; if (a_sc !== 16'd0) begin n_errors++; $display("FAIL flush_stall_cnt got=%0d exp=0", a_sc); end
        flush = 1'b0; stall = 1'b0; pc = 32'h500; tick(); tick(); tick();
        n_checks++; if (a_pc !== 32'h500) begin n_errors++; $display("FAIL flush_restart_pc got=%h exp=500", a_pc); end
    endtask

    task automatic test_saturation();
        do_reset();
        stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                n_checks++; if (c_sc !== 4'd14) begin n_errors++; $display("FAIL sat_14 got=%0d exp=14", c_sc); end
            end
            if (i == 15 || i == 20) begin
                n_checks++; if (c_sc !== 4'd15) begin n_errors++; $display("FAIL sat_%0d got=%0d exp=15", i, c_sc); end
            end
        end
        n_checks++; if (a_sc !== 16'd20) begin n_errors++; $display("FAIL sat_wide got=%0d exp=20", a_sc); end
        stall = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        n_checks++; if (c_sc !== 4'd0) begin n_errors++; $display("FAIL sat_reset got=%0d exp=0", c_sc); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        stall = 1'b1; tick(); stall = 1'b0;
        vin = 1'b1; pc = 32'h300; tick();
        pc = 32'h304; tick();
        n_checks++; if (c_occ !== 3'd2) begin n_errors++; $display("FAIL midrst_full_occ got=%0d exp=2", c_occ); end
        n_checks++; if (c_sc !== 4'd1) begin n_errors++; $display("FAIL midrst_pre_cnt got=%0d exp=1", c_sc); end
        stall = 1'b1; rst = 1'b1; tick();
        n_checks++; if (c_v !== 1'b0) begin n_errors++; $display("FAIL midrst_valid got=%b exp=0", c_v); end
        n_checks++; if (c_pc !== 32'h0) begin n_errors++; $display("FAIL midrst_pc got=%h exp=0", c_pc); end
        n_checks++; if (c_occ !== 3'd0) begin n_errors++; $display("FAIL midrst_occ got=%0d exp=0", c_occ); end
        n_checks++; if (c_sc !== 4'd0) begin n_errors++; $display("FAIL midrst_cnt got=%0d exp=0", c_sc); end
        rst = 1'b0; stall = 1'b0; pc = 32'h308; tick();
        n_checks++; if (c_v !== 1'b0) begin n_errors++; $display("FAIL midrst_lat1_valid got=%b exp=0", c_v); end
        pc = 32'h30C; tick();
        n_checks++; if (c_v !== 1'b1) begin n_errors++; $display("FAIL midrst_lat2_valid got=%b exp=1", c_v); end
        n_checks++; if (c_pc !== 32'h308) begin n_errors++; $display("FAIL midrst_lat2_pc got=%h exp=308", c_pc); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; vin = 1'b0; pc = '0; data = '0;
        test_reset();
        test_stream();
        test_hold_stall();
        test_bubble_stall();
        test_flush_with_stall();
        test_saturation();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
